// File: rtl/alu_mdu_seq.sv
// Sequential RV32I/RV64I ALU with iterative M-extension multiply/divide.
// Single-cycle ALU ops; radix-2 shift-add multiply and restoring divide behind valid/ready.
module alu_mdu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN),
  localparam int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_SLL    = 5'd5,  OP_SLT   = 5'd6,  OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8,  OP_SRL    = 5'd9,  OP_MUL   = 5'd10, OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV  = 5'd14, OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_REM  = 5'd16, OP_REMU   = 5'd17;

  state_t            state;
  logic [2*XLEN-1:0] acc_q;     // product (MUL) or partial remainder in the low half (DIV)
  logic [2*XLEN-1:0] mcand_q;   // shifted multiplicand (MUL) or divisor magnitude (DIV)
  logic [XLEN-1:0]   mplier_q;  // multiplier (MUL) or dividend shifting into quotient (DIV)
  logic [CNTW-1:0]   cnt_q;
  logic [XLEN-1:0]   res_q;
  logic              ill_q;
  logic              mul_lo_q, b_signed_q, rem_sel_q, neg_quo_q, neg_rem_q;

  // Accept-time decode and single-cycle ALU
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, a_mag, b_mag, special_res;
  logic            alu_ill, is_mul, is_div, div_signed, rem_op, a_signed, b_signed;
  logic            a_neg, b_neg, div_by_zero, div_ovf;

  assign shamt = in_b[SHW-1:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    alu_res = '0;
    alu_ill = 1'b0;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SLT:  alu_res = XLEN'($signed(in_a) < $signed(in_b));
      OP_SLTU: alu_res = XLEN'(in_a < in_b);
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      OP_SRL:  alu_res = in_a >> shamt;
      default: alu_ill = (in_op > OP_REMU);
    endcase
  end

  assign is_mul      = (in_op >= OP_MUL) && (in_op <= OP_MULHU);
  assign is_div      = (in_op >= OP_DIV) && (in_op <= OP_REMU);
  assign div_signed  = (in_op == OP_DIV) || (in_op == OP_REM);
  assign rem_op      = (in_op == OP_REM) || (in_op == OP_REMU);
  assign a_signed    = (in_op == OP_MULH) || (in_op == OP_MULHSU);
  assign b_signed    = (in_op == OP_MULH);
  assign a_neg       = div_signed & in_a[XLEN-1];
  assign b_neg       = div_signed & in_b[XLEN-1];
  assign a_mag       = a_neg ? -in_a : in_a;
  assign b_mag       = b_neg ? -in_b : in_b;
  assign div_by_zero = (in_b == '0);
  assign div_ovf     = div_signed && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
  assign special_res = div_by_zero ? (rem_op ? in_a : '1) : (rem_op ? '0 : in_a);

  // One iteration step of multiply and divide
  logic [2*XLEN-1:0] pp, prod_nx;
  logic [XLEN:0]     rem_sh, diff;
  logic [XLEN-1:0]   rem_nx, quo_nx, mul_res, div_res;
  logic              last;

  assign last    = (cnt_q == CNTW'(XLEN - 1));
  assign pp      = mplier_q[0] ? mcand_q : '0;
  // A signed multiplier's top bit weighs -2^(XLEN-1), so the final partial product is subtracted.
  assign prod_nx = (last && b_signed_q) ? acc_q - pp : acc_q + pp;
  assign mul_res = mul_lo_q ? prod_nx[XLEN-1:0] : prod_nx[2*XLEN-1:XLEN];

  assign rem_sh  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
  assign rem_nx  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nx  = {mplier_q[XLEN-2:0], ~diff[XLEN]};
  assign div_res = rem_sel_q ? (neg_rem_q ? -rem_nx : rem_nx) : (neg_quo_q ? -quo_nx : quo_nx);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so an aborted op leaves nothing visible behind.
      state      <= S_IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      ill_q      <= 1'b0;
      mul_lo_q   <= 1'b0;
      b_signed_q <= 1'b0;
      rem_sel_q  <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (kill) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          cnt_q      <= '0;
          acc_q      <= '0;
          ill_q      <= alu_ill;
          mul_lo_q   <= (in_op == OP_MUL);
          b_signed_q <= b_signed;
          rem_sel_q  <= rem_op;
          neg_quo_q  <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
          if (is_mul) begin
            mcand_q  <= a_signed ? {{XLEN{in_a[XLEN-1]}}, in_a} : {{XLEN{1'b0}}, in_a};
            mplier_q <= in_b;
            state    <= S_MUL;
          end else if (is_div && (div_by_zero || div_ovf)) begin
            res_q <= special_res;
            state <= S_DONE;
          end else if (is_div) begin
            mcand_q  <= {{XLEN{1'b0}}, b_mag};
            mplier_q <= a_mag;
            state    <= S_DIV;
          end else begin
            res_q <= alu_res;
            state <= S_DONE;
          end
        end
        S_MUL: begin
          acc_q    <= prod_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            res_q <= mul_res;
            state <= S_DONE;
          end
        end
        S_DIV: begin
          acc_q    <= {{XLEN{1'b0}}, rem_nx};
          mplier_q <= quo_nx;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            res_q <= div_res;
            state <= S_DONE;
          end
        end
        S_DONE:  if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state == S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign out_result  = res_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq at XLEN=32 and XLEN=64 with hand-computed expectations.
// Checks results, exact latency, backpressure, kill and mid-operation reset.
module tb_alu_mdu_seq;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd5, SLT = 5'd6, SLTU = 5'd7, SRA = 5'd8;
  localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13;
  localparam logic [4:0] DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;

  logic        clk = 1'b0, rst_n = 1'b0, kill = 1'b0, out_ready = 1'b0;
  logic        v32 = 1'b0, v64 = 1'b0;
  logic [4:0]  op = '0;
  logic [63:0] a = '0, b = '0;

  logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0] r32;
  logic [63:0] r64;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .kill(kill),
    .in_valid(v32), .in_ready(rdy32), .in_op(op), .in_a(a[31:0]), .in_b(b[31:0]),
    .out_valid(ov32), .out_ready(out_ready), .out_result(r32), .out_illegal(ill32)
  );

  alu_mdu_seq #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .kill(kill),
    .in_valid(v64), .in_ready(rdy64), .in_op(op), .in_a(a), .in_b(b),
    .out_valid(ov64), .out_ready(out_ready), .out_result(r64), .out_illegal(ill64)
  );

  function automatic logic [63:0] res_of(input int w);
    return (w == 32) ? {32'h0, r32} : r64;
  endfunction
  function automatic logic valid_of(input int w);
    return (w == 32) ? ov32 : ov64;
  endfunction
  function automatic logic ready_of(input int w);
    return (w == 32) ? rdy32 : rdy64;
  endfunction
  function automatic logic ill_of(input int w);
    return (w == 32) ? ill32 : ill64;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one op, return #1 after the accept edge with operands scrambled.
  task automatic issue(input int w, input logic [4:0] o, input logic [63:0] aa, input logic [63:0] bb);
    @(negedge clk);
    op = o; a = aa; b = bb;
    if (w == 32) v32 = 1'b1; else v64 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    op = 5'($urandom_range(0, 31));
  endtask

  // Cycle N+1 is the first cycle after accept; report the cycle out_valid first rises.
  task automatic wait_valid(input int w, input int lat, input string tag);
    int cyc = 1;
    while (!valid_of(w) && cyc < lat + 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":latency"}, 64'(cyc), 64'(lat));
  endtask

  task automatic run_op(input int w, input logic [4:0] o, input logic [63:0] aa, input logic [63:0] bb,
                        input int lat, input logic [63:0] exp, input logic exp_ill, input string tag);
    issue(w, o, aa, bb);
    wait_valid(w, lat, tag);
    check({tag, ":result"}, res_of(w), exp);
    check({tag, ":illegal"}, 64'(ill_of(w)), 64'(exp_ill));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":handoff"}, {62'h0, valid_of(w), ready_of(w)}, 64'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    #12;
    check("reset32", {59'h0, rdy32, ov32, ill32, |r32, 1'b0}, {59'h0, 5'b10000});
    check("reset64", {59'h0, rdy64, ov64, ill64, |r64, 1'b0}, {59'h0, 5'b10000});
    @(negedge clk); rst_n = 1'b1;

    // XLEN = 32
    run_op(32, ADD,  64'hFFFFFFFF, 64'h1,  1, 64'h0, 1'b0, "add32_wrap");
    run_op(32, SUB,  64'h0, 64'h1,          1, 64'hFFFFFFFF, 1'b0, "sub32_wrap");
    run_op(32, SLL,  64'h1, 64'h3F,         1, 64'h80000000, 1'b0, "sll32");
    run_op(32, SRA,  64'h80000000, 64'h21,  1, 64'hC0000000, 1'b0, "sra32");
    run_op(32, SLT,  64'hFFFFFFFF, 64'h1,   1, 64'h1, 1'b0, "slt32");
    run_op(32, SLTU, 64'hFFFFFFFF, 64'h1,   1, 64'h0, 1'b0, "sltu32");
    run_op(32, MULH, 64'h80000000, 64'h80000000, 33, 64'h40000000, 1'b0, "mulh32");
    run_op(32, MULHU, 64'hFFFFFFFF, 64'hFFFFFFFF, 33, 64'hFFFFFFFE, 1'b0, "mulhu32");
    run_op(32, MULHSU, 64'hFFFFFFFF, 64'h2, 33, 64'hFFFFFFFF, 1'b0, "mulhsu32");
    run_op(32, MUL,  64'h7, 64'hFFFFFFFD,   33, 64'hFFFFFFEB, 1'b0, "mul32");
    run_op(32, DIV,  64'hFFFFFFF9, 64'h2,   33, 64'hFFFFFFFD, 1'b0, "div32");
    run_op(32, REM,  64'hFFFFFFF9, 64'h2,   33, 64'hFFFFFFFF, 1'b0, "rem32");
    run_op(32, DIVU, 64'd100, 64'd7,        33, 64'd14, 1'b0, "divu32");
    run_op(32, REMU, 64'd100, 64'd7,        33, 64'd2, 1'b0, "remu32");
    run_op(32, DIVU, 64'd5, 64'd0,          1, 64'hFFFFFFFF, 1'b0, "divu32_by0");
    run_op(32, REMU, 64'd5, 64'd0,          1, 64'd5, 1'b0, "remu32_by0");
    run_op(32, DIV,  64'h80000000, 64'hFFFFFFFF, 1, 64'h80000000, 1'b0, "div32_ovf");
    run_op(32, REM,  64'h80000000, 64'hFFFFFFFF, 1, 64'h0, 1'b0, "rem32_ovf");
    run_op(32, 5'd20, 64'h1234, 64'h5678,   1, 64'h0, 1'b1, "illegal32");
    run_op(32, ADD,  64'h2, 64'h3,          1, 64'h5, 1'b0, "illegal_clears");

    // Backpressure: result held, no accept while DONE, and none in the handoff cycle.
    issue(32, DIV, 64'd100, 64'd7);
    wait_valid(32, 33, "bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {rdy32, ov32, 30'h0, r32}, {1'b0, 1'b1, 30'h0, 32'd14});
    end
    @(negedge clk); out_ready = 1'b1; v32 = 1'b1; op = ADD; a = 64'h1; b = 64'h1;
    @(posedge clk); #1;
    check("bp_handoff", {62'h0, ov32, rdy32}, 64'h1);
    @(negedge clk); out_ready = 1'b0; v32 = 1'b0;
    @(posedge clk); #1;
    check("bp_no_accept_in_handoff", {62'h0, ov32, rdy32}, 64'h1);

    // Kill during a DIVU at cycle N+10.
    issue(32, DIVU, 64'd1000, 64'd3);
    repeat (9) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    check("kill_div", {62'h0, ov32, rdy32}, 64'h1);
    @(negedge clk); kill = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= ov32;
    end
    check("kill_div_no_result", 64'(seen), 64'h0);

    // Kill in IDLE blocks the accept.
    @(negedge clk); kill = 1'b1; v32 = 1'b1; op = ADD; a = 64'h1; b = 64'h1;
    @(posedge clk); #1;
    check("kill_idle", {62'h0, ov32, rdy32}, 64'h1);
    @(negedge clk); kill = 1'b0; v32 = 1'b0;
    @(posedge clk); #1;
    check("kill_idle_no_accept", 64'(ov32), 64'h0);

    // Kill wins over a handshake in DONE.
    issue(32, ADD, 64'h2, 64'h3);
    wait_valid(32, 1, "kill_done");
    @(negedge clk); kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("kill_done", {62'h0, ov32, rdy32}, 64'h1);
    @(negedge clk); kill = 1'b0; out_ready = 1'b0;

    // Reset mid-MUL: outputs return to reset values without a clock edge.
    issue(32, MUL, 64'h3, 64'h5);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst_mid_mul", {rdy32, ov32, ill32, 29'h0, r32}, 64'h8000_0000_0000_0000);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= ov32;
    end
    check("rst_mid_mul_no_result", 64'(seen), 64'h0);

    // XLEN = 64
    run_op(64, ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 64'h0, 1'b0, "add64_wrap");
    run_op(64, SRA,  64'h8000_0000_0000_0000, 64'h41, 1, 64'hC000_0000_0000_0000, 1'b0, "sra64");
    run_op(64, SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 64'h1, 1'b0, "slt64");
    run_op(64, SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 64'h0, 1'b0, "sltu64");
    run_op(64, MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65,
           64'h4000_0000_0000_0000, 1'b0, "mulh64");
    run_op(64, MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "mulhu64");
    run_op(64, MULHU, 64'h1_0000_0000, 64'h1_0000_0000, 65, 64'h1, 1'b0, "mulhu64_mid");
    run_op(64, MUL,  64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "mul64");
    run_op(64, DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div64");
    run_op(64, REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "rem64");
    run_op(64, DIVU, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "divu64_by0");
    run_op(64, REMU, 64'd5, 64'd0, 1, 64'd5, 1'b0, "remu64_by0");
    run_op(64, DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
           64'h8000_0000_0000_0000, 1'b0, "div64_ovf");
    run_op(64, REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0, 1'b0, "rem64_ovf");
    run_op(64, 5'd20, 64'h1234, 64'h5678, 1, 64'h0, 1'b1, "illegal64");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
